seq_stage_ctrl: RTL and testbench
=================================

// Module: seq_stage_ctrl
// PURPOSE
//  Multi-cycle sequencer for the Y86-64 SEQ datapath. Steps fetch, decode, execute, memory,
//  writeback and PC-update one stage per cycle. Drives stage enables, CC-set, data-memory
//  request handshake, register-write and next-PC select. Tracks processor status
//  (AOK/HLT/ADR/INS). Sits beside the execute unit and consumes its cnd output.
// PARAMETERS
//  MEM_TIMEOUT  16  max MEMORY-state cycles waiting for mem_ready before ADR fault (>=1)
//  RETIRE_W     32  width of retired-instruction counter
// PORTS
//  clock        in   1         single clock, rising edge
//  reset        in   1         synchronous, active-high
//  start        in   1         pulse in IDLE: begin running at FETCH
//  icode        in   4         fetched instruction code (valid during FETCH)
//  ifun         in   4         fetched function code (valid during FETCH)
//  instr_valid  in   1         fetch decode says icode/ifun legal
//  imem_error   in   1         fetch address fault
//  cnd          in   1         condition from execute unit, sampled in EXECUTE
//  mem_ready    in   1         data memory done (read data valid / write accepted)
//  dmem_error   in   1         data memory fault, qualified by mem_ready
//  state        out  3         IDLE=0 FETCH=1 DECODE=2 EXEC=3 MEM=4 WB=5 PCUPD=6 HALT=7
//  fetch_en/decode_en/exec_en  out 1 each  high in own state only
//  set_cc       out  1         EXEC and icode==6 (OPq)
//  mem_rd       out  1         MEM and icode in {5,9,B}; held until mem_ready
//  mem_wr       out  1         MEM and icode in {4,8,A}; held until mem_ready
//  wb_en        out  1         WB and icode in {3,5,6,8,9,A,B}, or icode==2 with cnd_q
//  pc_en        out  1         PCUPD
//  pc_sel       out  2         0=valP 1=valC (call, or jXX with cnd_q) 2=valM (ret)
//  stat         out  3         1=AOK 2=HLT 3=ADR 4=INS
//  retired      out  RETIRE_W  instructions completed through PCUPD
// BEHAVIOUR
//  - Reset: state=IDLE, stat=AOK, retired=0, cnd_q=0, all strobes 0, pc_sel=0, timeout ctr=0.
//  - Outputs are Moore: decoded from state reg + latched icode_q/ifun_q/cnd_q; no comb path from inputs.
//  - IDLE -start-> FETCH. start ignored in all other states.
//  - FETCH: latch icode/ifun. imem_error -> HALT, stat=ADR (priority). else !instr_valid -> HALT,
//    stat=INS. else icode==0 -> HALT, stat=HLT. else -> DECODE.
//  - DECODE->EXEC->MEM, one cycle each. EXEC latches cnd into cnd_q.
//  - MEM: no access -> WB after 1 cycle. Access -> stay until mem_ready; dmem_error with mem_ready
//    -> HALT, stat=ADR, WB/PCUPD skipped. Counter reaches MEM_TIMEOUT without mem_ready -> HALT, ADR.
//    mem_ready+dmem_error same cycle: error wins. Timeout ctr clears on MEM exit.
//  - WB->PCUPD->FETCH, one cycle each; retired += 1 on PCUPD exit (wraps mod 2^RETIRE_W).
//  - Non-memory instruction: 6 cycles FETCH..PCUPD. Memory instruction: 5 + MEM wait cycles.
//  - HALT sticky until reset; all strobes 0; stat frozen.
//  - Reset mid-operation (any state incl. MEM wait): next cycle IDLE, mem_rd/mem_wr low.
//  - icode/ifun sampled only in FETCH; changes elsewhere ignored.
// CONFIGURATION
//  SEQ_CTRL_SINGLE_STEP_EN defined: adds input `step` (1b). After PCUPD go to IDLE, not FETCH;
//   each start or step pulse in IDLE runs exactly one instruction. Undefined: free-run PCUPD->FETCH,
//   no step port.
// TESTING
//  1 reset 3 cycles, start=1 1 cycle, icode=6 ifun=0 -> FETCH..PCUPD 6 cycles, set_cc only in EXEC, wb_en in WB, retired=1.
//  2 icode=5, mem_ready after 3 MEM cycles -> mem_rd high exactly 3 cycles, then wb_en, pc_sel=0.
//  3 icode=7 cnd=1 -> pc_sel=1 in PCUPD, wb_en=0; icode=2 cnd=0 -> wb_en=0.
//  4 icode=4, mem_ready never, MEM_TIMEOUT=4 -> HALT after 4 MEM cycles, stat=3, retired unchanged.
//  5 instr_valid=0 in FETCH -> HALT, stat=4; imem_error=1 with instr_valid=0 -> stat=3.
//  6 icode=0 -> HALT stat=2, start ignored; reset during MEM wait -> IDLE, mem_wr=0 next cycle, stat=1.

Source files
------------

// File: rtl/seq_stage_ctrl.sv
// seq_stage_ctrl: Y86-64 SEQ stage sequencer and status tracker; defining SEQ_CTRL_SINGLE_STEP_EN adds a step input that runs one instruction per start/step pulse
module seq_stage_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int RETIRE_W = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
`ifdef SEQ_CTRL_SINGLE_STEP_EN
  input  logic                step,
`endif
  input  logic [3:0]          icode,
  input  logic [3:0]          ifun,
  input  logic                instr_valid,
  input  logic                imem_error,
  input  logic                cnd,
  input  logic                mem_ready,
  input  logic                dmem_error,
  output logic [2:0]          state,
  output logic                fetch_en,
  output logic                decode_en,
  output logic                exec_en,
  output logic                set_cc,
  output logic                mem_rd,
  output logic                mem_wr,
  output logic                wb_en,
  output logic                pc_en,
  output logic [1:0]          pc_sel,
  output logic [2:0]          stat,
  output logic [RETIRE_W-1:0] retired
);
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB, PCUPD, HALT} state_t;
  localparam logic [2:0] AOK = 3'd1;
  localparam logic [2:0] HLT = 3'd2;
  localparam logic [2:0] ADR = 3'd3;
  localparam logic [2:0] INS = 3'd4;
  localparam int TW = $clog2(MEM_TIMEOUT + 1);
  state_t st, st_n;
  logic [TW-1:0] tmo, tmo_n;
  logic [3:0] icode_q, icode_n, ifun_q, ifun_n;
  logic cnd_q, cnd_n, go, acc, unused_ifun;
  logic [2:0] stat_n;
`ifdef SEQ_CTRL_SINGLE_STEP_EN
  localparam bit STEP_MODE = 1'b1;
  assign go = start | step;
`else
  localparam bit STEP_MODE = 1'b0;
  assign go = start;
`endif
  assign state = st;
  assign unused_ifun = ^ifun_q;
  assign acc = icode_q inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
  always_comb begin
    st_n = st;
    stat_n = stat;
    icode_n = icode_q;
    ifun_n = ifun_q;
    cnd_n = cnd_q;
    tmo_n = '0;
    case (st)
      IDLE: st_n = go ? FETCH : IDLE;
      FETCH: begin
        icode_n = icode;
        ifun_n = ifun;
        st_n = (imem_error || !instr_valid || icode == 4'h0) ? HALT : DECODE;
        stat_n = imem_error ? ADR : !instr_valid ? INS : (icode == 4'h0) ? HLT : AOK;
      end
      DECODE: st_n = EXEC;
      EXEC: begin
        st_n = MEM;
        cnd_n = cnd;
      end
      MEM: begin
        if (!acc) begin
          st_n = WB;
        end else if (mem_ready) begin
          st_n = dmem_error ? HALT : WB;
          stat_n = dmem_error ? ADR : stat;
        end else if (tmo == TW'(MEM_TIMEOUT - 1)) begin
          st_n = HALT;
          stat_n = ADR;
        end else begin
          tmo_n = tmo + 1'b1;
        end
      end
      WB: st_n = PCUPD;
      PCUPD: st_n = STEP_MODE ? IDLE : FETCH;
      default: st_n = HALT;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      st <= IDLE;
      stat <= AOK;
      retired <= '0;
      cnd_q <= 1'b0;
      icode_q <= 4'h0;
      ifun_q <= 4'h0;
      tmo <= '0;
      fetch_en <= 1'b0;
      decode_en <= 1'b0;
      exec_en <= 1'b0;
      set_cc <= 1'b0;
      mem_rd <= 1'b0;
      mem_wr <= 1'b0;
      wb_en <= 1'b0;
      pc_en <= 1'b0;
      pc_sel <= 2'd0;
    end else begin
      st <= st_n;
      stat <= stat_n;
      cnd_q <= cnd_n;
      icode_q <= icode_n;
      ifun_q <= ifun_n;
      tmo <= tmo_n;
      if (st == PCUPD) retired <= retired + 1'b1;
      fetch_en <= st_n == FETCH;
      decode_en <= st_n == DECODE;
      exec_en <= st_n == EXEC;
      set_cc <= st_n == EXEC && icode_n == 4'h6;
      mem_rd <= st_n == MEM && icode_n inside {4'h5, 4'h9, 4'hB};
      mem_wr <= st_n == MEM && icode_n inside {4'h4, 4'h8, 4'hA};
      wb_en <= st_n == WB && (icode_n inside {4'h3, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB} || (icode_n == 4'h2 && cnd_n));
      pc_en <= st_n == PCUPD;
      pc_sel <= (st_n != PCUPD) ? 2'd0 : (icode_n == 4'h9) ? 2'd2 : (icode_n == 4'h8 || (icode_n == 4'h7 && cnd_n)) ? 2'd1 : 2'd0;
    end
  end
endmodule

// File: tb/tb_seq_stage_ctrl.sv
// tb_seq_stage_ctrl: directed and randomized instruction sequences checked against a stage-list reference model
module tb_seq_stage_ctrl;
  localparam int TO = 4;
  localparam int RW = 3;
  logic clock = 1'b0;
  logic reset, start, instr_valid, imem_error, cnd, mem_ready, dmem_error;
  logic [3:0] icode, ifun;
  logic [2:0] state, stat;
  logic fetch_en, decode_en, exec_en, set_cc, mem_rd, mem_wr, wb_en, pc_en;
  logic [1:0] pc_sel;
  logic [RW-1:0] retired;
  int errors = 0;
  int checks = 0;
  int es, estat, eret;
  logic [3:0] eic;
  logic ecq;
  bit [15:0] rd_set = 16'h0A20;
  bit [15:0] wr_set = 16'h0510;
  bit [15:0] wb_set = 16'h0F68;
  always #5 clock = ~clock;
  seq_stage_ctrl #(.MEM_TIMEOUT(TO), .RETIRE_W(RW)) dut (
    .clock(clock), .reset(reset), .start(start), .icode(icode), .ifun(ifun),
    .instr_valid(instr_valid), .imem_error(imem_error), .cnd(cnd),
    .mem_ready(mem_ready), .dmem_error(dmem_error), .state(state),
    .fetch_en(fetch_en), .decode_en(decode_en), .exec_en(exec_en), .set_cc(set_cc),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .wb_en(wb_en), .pc_en(pc_en),
    .pc_sel(pc_sel), .stat(stat), .retired(retired)
  );
  task automatic tick;
    @(posedge clock);
    #1;
  endtask
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // expected {fetch,decode,exec,set_cc,mem_rd,mem_wr,wb_en,pc_en,pc_sel} for a stage
  function automatic logic [9:0] exp_o(input int s, input logic [3:0] ic, input logic cq);
    logic [1:0] ps;
    ps = (s != 6) ? 2'd0 : (ic == 4'h9) ? 2'd2 : (ic == 4'h8 || (ic == 4'h7 && cq)) ? 2'd1 : 2'd0;
    return {s == 1, s == 2, s == 3, s == 3 && ic == 4'h6, s == 4 && rd_set[ic], s == 4 && wr_set[ic],
            s == 5 && (wb_set[ic] || (ic == 4'h2 && cq)), s == 6, ps};
  endfunction
  task automatic check_all(input string tag);
    chk({tag, ".state"}, 16'(state), 16'(es));
    chk({tag, ".strobes"}, 16'({fetch_en, decode_en, exec_en, set_cc, mem_rd, mem_wr, wb_en, pc_en, pc_sel}), 16'(exp_o(es, eic, ecq)));
    chk({tag, ".stat"}, 16'(stat), 16'(estat));
    chk({tag, ".retired"}, 16'(retired), 16'(eret));
  endtask
  task automatic do_reset;
    reset = 1'b1;
    start = 1'b0;
    repeat (2) tick;
    reset = 1'b0;
    es = 0;
    estat = 1;
    eret = 0;
    ecq = 1'b0;
    check_all("reset");
  endtask
  task automatic go;
    start = 1'b1;
    tick;
    start = 1'b0;
    es = 1;
    check_all("start");
  endtask
  task automatic halt_sticky;
    start = 1'b1;
    repeat (2) tick;
    start = 1'b0;
    check_all("halt_sticky");
  endtask
  task automatic run_instr(input string tag, input logic [3:0] ic, input logic [3:0] fn, input bit valid,
                           input bit ierr, input bit c, input int wait_n, input bit derr, input int rst_k);
    icode = ic;
    ifun = fn;
    instr_valid = valid;
    imem_error = ierr;
    cnd = 1'($urandom);
    mem_ready = 1'($urandom);
    dmem_error = 1'($urandom);
    tick;
    eic = ic;
    if (ierr) begin
      es = 7;
      estat = 3;
    end else if (!valid) begin
      es = 7;
      estat = 4;
    end else if (ic == 4'h0) begin
      es = 7;
      estat = 2;
    end else begin
      es = 2;
    end
    check_all({tag, ".fetch"});
    instr_valid = 1'($urandom);
    imem_error = 1'($urandom);
    if (es == 7) return;
    icode = 4'($urandom);
    start = 1'($urandom);
    tick;
    es = 3;
    check_all({tag, ".decode"});
    cnd = c;
    tick;
    ecq = c;
    es = 4;
    check_all({tag, ".exec"});
    cnd = 1'($urandom);
    icode = 4'($urandom);
    if (!(rd_set[ic] || wr_set[ic])) begin
      mem_ready = 1'($urandom);
      dmem_error = 1'($urandom);
      tick;
      es = 5;
      check_all({tag, ".mem"});
    end else begin
      for (int k = 1; es == 4; k++) begin
        if (k == rst_k) begin
          reset = 1'b1;
          tick;
          reset = 1'b0;
          start = 1'b0;
          es = 0;
          estat = 1;
          eret = 0;
          ecq = 1'b0;
          check_all({tag, ".midreset"});
          return;
        end
        if (k == wait_n) begin
          mem_ready = 1'b1;
          dmem_error = derr;
        end else begin
          mem_ready = 1'b0;
          dmem_error = 1'($urandom);
        end
        tick;
        if (k == wait_n) begin
          es = derr ? 7 : 5;
          if (derr) estat = 3;
        end else if (k == TO) begin
          es = 7;
          estat = 3;
        end
        check_all($sformatf("%s.mem%0d", tag, k));
      end
    end
    mem_ready = 1'($urandom);
    if (es == 7) begin
      start = 1'b0;
      return;
    end
    tick;
    es = 6;
    check_all({tag, ".wb"});
    start = 1'b0;
    tick;
    es = 1;
    eret = (eret + 1) % (1 << RW);
    check_all({tag, ".pcupd"});
  endtask
  initial begin
    reset = 1'b1;
    start = 1'b0;
    icode = 4'h0;
    ifun = 4'h0;
    instr_valid = 1'b1;
    imem_error = 1'b0;
    cnd = 1'b0;
    mem_ready = 1'b0;
    dmem_error = 1'b0;
    es = 0;
    estat = 1;
    eret = 0;
    eic = 4'h0;
    ecq = 1'b0;
    repeat (3) tick;
    reset = 1'b0;
    check_all("por");
    repeat (2) tick;
    check_all("idle_hold");
    go;
    run_instr("opq", 4'h6, 4'h0, 1, 0, 0, 0, 0, 0);
    run_instr("mrmovq", 4'h5, 4'h0, 1, 0, 1, 3, 0, 0);
    run_instr("jxx_t", 4'h7, 4'h1, 1, 0, 1, 0, 0, 0);
    run_instr("jxx_nt", 4'h7, 4'h2, 1, 0, 0, 0, 0, 0);
    run_instr("cmov_nt", 4'h2, 4'h3, 1, 0, 0, 0, 0, 0);
    run_instr("cmov_t", 4'h2, 4'h3, 1, 0, 1, 0, 0, 0);
    run_instr("call", 4'h8, 4'h0, 1, 0, 0, 1, 0, 0);
    run_instr("ret", 4'h9, 4'h0, 1, 0, 0, 2, 0, 0);
    run_instr("rmmov_last", 4'h4, 4'h0, 1, 0, 0, TO, 0, 0);
    run_instr("tmo", 4'h4, 4'h0, 1, 0, 0, 0, 0, 0);
    halt_sticky;
    do_reset;
    go;
    run_instr("ins", 4'h3, 4'h0, 0, 0, 0, 0, 0, 0);
    halt_sticky;
    do_reset;
    go;
    run_instr("iadr", 4'h3, 4'h0, 0, 1, 0, 0, 0, 0);
    do_reset;
    go;
    run_instr("derr", 4'hB, 4'h0, 1, 0, 0, 2, 1, 0);
    halt_sticky;
    do_reset;
    go;
    run_instr("hlt", 4'h0, 4'h0, 1, 0, 0, 0, 0, 0);
    halt_sticky;
    do_reset;
    go;
    run_instr("rst_mem", 4'hA, 4'h0, 1, 0, 0, 0, 0, 2);
    go;
    for (int i = 0; i < 9; i++) run_instr("wrap", 4'h1, 4'h0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 80; i++) begin
      logic [3:0] ic;
      bit v;
      ic = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'($urandom_range(1, 11));
      v = (ic <= 4'hB) && ($urandom_range(0, 19) != 0);
      run_instr($sformatf("rnd%0d", i), ic, 4'($urandom), v, $urandom_range(0, 29) == 0,
                1'($urandom), $urandom_range(1, TO + 1), $urandom_range(0, 9) == 0, 0);
      if (es == 7) begin
        halt_sticky;
        do_reset;
        go;
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
